// File: rtl/char_draw_pkg.sv
`default_nettype none
// ============================================================================
// Module  : char_draw_pkg
// Brief   : Shared constants for the character sprite renderer.
// Revision: 1.0 - initial release
// ============================================================================
package char_draw_pkg;

    localparam int c_colour_w = 3;
    localparam int c_sprite_w = 8;
    localparam int c_sprite_h = 8;
    localparam int c_screen_w = 160;
    localparam int c_screen_h = 120;
    localparam int c_rom_aw   = $clog2(c_sprite_w * c_sprite_h);

    localparam int c_state_w = 2;
    localparam logic [c_state_w-1:0] c_st_idle  = 2'd0;
    localparam logic [c_state_w-1:0] c_st_erase = 2'd1;
    localparam logic [c_state_w-1:0] c_st_draw  = 2'd2;
    localparam logic [c_state_w-1:0] c_st_done  = 2'd3;

    // One octal digit per pixel; address 0 is the least-significant digit.
    localparam logic [c_sprite_w*c_sprite_h*c_colour_w-1:0] c_sprite_image =
        192'o12346701_23467012_34670125_46701234_67012345_70123456_05123467_12534670;

endpackage
`default_nettype wire

// File: rtl/character_sprite_draw_if.sv
`default_nettype none
// ============================================================================
// Module  : character_sprite_draw_if
// Brief   : Redraw request and VGA plot port of the sprite renderer.
// Revision: 1.0 - initial release
// ============================================================================
interface character_sprite_draw_if;
    import char_draw_pkg::*;

    logic                  enable;
    logic [7:0]            x_position;
    logic [6:0]            y_position;
    logic [7:0]            vga_x;
    logic [6:0]            vga_y;
    logic [c_colour_w-1:0] vga_colour;
    logic                  vga_plot;
    logic                  busy;
    logic                  done;

    modport master (
        output enable, x_position, y_position,
        input  vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

    modport slave (
        input  enable, x_position, y_position,
        output vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/character_sprite_rom.sv
`default_nettype none
// ============================================================================
// Module  : character_sprite_rom
// Brief   : Sprite colour ROM, one-cycle registered read.
// Revision: 1.0 - initial release
// ============================================================================
module character_sprite_rom
    import char_draw_pkg::*;
#(
    parameter int ADDR_W = c_rom_aw
) (
    input  wire logic                  clock,
    input  wire logic [ADDR_W-1:0]     addr,
    output logic      [c_colour_w-1:0] colour
);

    localparam int c_depth = 2 ** ADDR_W;

    logic [c_colour_w-1:0] w_mem [c_depth];

    generate
        for (genvar gi = 0; gi < c_depth; gi++) begin : g_mem
            assign w_mem[gi] = c_sprite_image[gi*c_colour_w +: c_colour_w];
        end
    endgenerate

    always_ff @(posedge clock) begin
        colour <= w_mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/character_sprite_draw.sv
`default_nettype none
// ============================================================================
// Module  : character_sprite_draw
// Brief   : Erases the sprite at its old position, then draws it at the new
//           one, one pixel per clock. Build option: SPRITE_TRANSPARENCY_EN.
// Revision: 1.0 - initial release
// ============================================================================
module character_sprite_draw
    import char_draw_pkg::*;
#(
    parameter int                    SPRITE_W  = c_sprite_w,
    parameter int                    SPRITE_H  = c_sprite_h,
    parameter int                    SCREEN_W  = c_screen_w,
    parameter int                    SCREEN_H  = c_screen_h,
    parameter logic [c_colour_w-1:0] BG_COLOUR = 3'b000
`ifdef SPRITE_TRANSPARENCY_EN
    ,parameter logic [c_colour_w-1:0] TRANSPARENT_COLOUR = 3'b101
`endif
) (
    input wire logic                clock,
    input wire logic                resetn,
    character_sprite_draw_if.slave  bus
);

    localparam int c_col_w  = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int c_row_w  = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam int c_addr_w = $clog2(SPRITE_W * SPRITE_H);
    localparam logic [c_col_w-1:0] c_col_last = c_col_w'(SPRITE_W - 1);
    localparam logic [c_row_w-1:0] c_row_last = c_row_w'(SPRITE_H - 1);

    logic [c_state_w-1:0]  r_state;
    logic [c_state_w-1:0]  w_state_nxt;
    logic [c_col_w-1:0]    r_col;
    logic [c_col_w-1:0]    w_col_nxt;
    logic [c_row_w-1:0]    r_row;
    logic [c_row_w-1:0]    w_row_nxt;
    logic                  r_drain;
    logic [7:0]            r_new_x;
    logic [6:0]            r_new_y;
    logic [7:0]            r_old_x;
    logic [6:0]            r_old_y;
    logic                  r_have_old;
    logic [7:0]            r_vga_x;
    logic [6:0]            r_vga_y;
    logic [c_colour_w-1:0] r_vga_colour;
    logic                  r_vga_plot;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_scan;
    logic                  w_px_valid;
    logic                  w_last_px;
    logic                  w_clip;
    logic                  w_transparent;
    logic [7:0]            w_base_x;
    logic [6:0]            w_base_y;
    logic [8:0]            w_wide_x;
    logic [7:0]            w_wide_y;
    logic [c_addr_w-1:0]   w_rom_addr;
    logic [c_colour_w-1:0] w_rom_colour;

    assign w_scan     = (r_state == c_st_erase) || (r_state == c_st_draw);
    assign w_px_valid = w_scan && !r_drain;
    assign w_last_px  = (r_row == c_row_last) && (r_col == c_col_last);

    assign w_base_x = (r_state == c_st_erase) ? r_old_x : r_new_x;
    assign w_base_y = (r_state == c_st_erase) ? r_old_y : r_new_y;
    assign w_wide_x = {1'b0, w_base_x} + 9'(r_col);
    assign w_wide_y = {1'b0, w_base_y} + 8'(r_row);
    assign w_clip   = (w_wide_x >= 9'(SCREEN_W)) || (w_wide_y >= 8'(SCREEN_H));

    // Counters return to 0 outside a scan so each pass starts at pixel 0.
    always_comb begin
        w_col_nxt = '0;
        w_row_nxt = '0;
        if (w_px_valid && !w_last_px) begin
            if (r_col == c_col_last) begin
                w_row_nxt = r_row + 1'b1;
            end else begin
                w_row_nxt = r_row;
                w_col_nxt = r_col + 1'b1;
            end
        end
    end

    // ROM is addressed with next-cycle coordinates so its registered output
    // lines up with the current scan slot.
    assign w_rom_addr = c_addr_w'(w_row_nxt) * c_addr_w'(SPRITE_W) + c_addr_w'(w_col_nxt);

    character_sprite_rom #(
        .ADDR_W (c_addr_w)
    ) u_rom (
        .clock  (clock),
        .addr   (w_rom_addr),
        .colour (w_rom_colour)
    );

`ifdef SPRITE_TRANSPARENCY_EN
    assign w_transparent = (r_state == c_st_draw) && (w_rom_colour == TRANSPARENT_COLOUR);
`else
    assign w_transparent = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (bus.enable) w_state_nxt = r_have_old ? c_st_erase : c_st_draw;
            c_st_erase: if (r_drain)    w_state_nxt = c_st_draw;
            c_st_draw:  if (r_drain)    w_state_nxt = c_st_done;
            c_st_done:                  w_state_nxt = c_st_idle;
            default:                    w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_busy = (r_state != c_st_idle);
        w_done = (r_state == c_st_done);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_col        <= '0;
            r_row        <= '0;
            r_drain      <= 1'b0;
            r_new_x      <= '0;
            r_new_y      <= '0;
            r_old_x      <= '0;
            r_old_y      <= '0;
            r_have_old   <= 1'b0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
        end else begin
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_drain <= w_px_valid && w_last_px;
            if ((r_state == c_st_idle) && bus.enable) begin
                r_new_x <= bus.x_position;
                r_new_y <= bus.y_position;
            end
            if (r_state == c_st_done) begin
                r_old_x    <= r_new_x;
                r_old_y    <= r_new_y;
                r_have_old <= 1'b1;
            end
            r_vga_plot <= w_px_valid && !w_clip && !w_transparent;
            if (w_px_valid) begin
                r_vga_x      <= w_wide_x[7:0];
                r_vga_y      <= w_wide_y[6:0];
                r_vga_colour <= (r_state == c_st_erase) ? BG_COLOUR : w_rom_colour;
            end
        end
    end

    assign bus.vga_x      = r_vga_x;
    assign bus.vga_y      = r_vga_y;
    assign bus.vga_colour = r_vga_colour;
    assign bus.vga_plot   = r_vga_plot;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;

endmodule
`default_nettype wire

// File: tb/tb_character_sprite_draw.sv
`default_nettype none
// ============================================================================
// Module  : tb_character_sprite_draw
// Brief   : Directed scoreboard bench for character_sprite_draw.
// Revision: 1.0 - initial release
// ============================================================================
module tb_character_sprite_draw;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic clock = 1'b0;
    logic resetn;

    character_sprite_draw_if bus_if ();

    character_sprite_draw u_dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus_if)
    );

    always #5 clock = ~clock;

    int   checks   = 0;
    int   failures = 0;
    int   n_plots  = 0;
    int   exp_plots;
    pix_t sb[$];

    int m_have_old = 0;
    int m_old_x    = 0;
    int m_old_y    = 0;

    logic [191:0] tb_sprite =
        192'o12346701_23467012_34670125_46701234_67012345_70123456_05123467_12534670;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] tb_rom(input int a);
        return tb_sprite[a*3 +: 3];
    endfunction

    // Reference model: queue every pixel the redraw must plot, in order.
    task automatic push_expected(input int nx, input int ny, output int done_cyc);
        int wx;
        int wy;
        logic [2:0] col;
        exp_plots = 0;
        if (m_have_old != 0) begin
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    wx = m_old_x + c;
                    wy = m_old_y + r;
                    if (wx < 160 && wy < 120) begin
                        sb.push_back(pix_t'{8'(wx), 7'(wy), 3'b000});
                        exp_plots++;
                    end
                end
            end
        end
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                wx  = nx + c;
                wy  = ny + r;
                col = tb_rom(r*8 + c);
`ifdef SPRITE_TRANSPARENCY_EN
                if (col == 3'b101) continue;
`endif
                if (wx < 160 && wy < 120) begin
                    sb.push_back(pix_t'{8'(wx), 7'(wy), col});
                    exp_plots++;
                end
            end
        end
        done_cyc   = (m_have_old != 0) ? 131 : 66;
        m_have_old = 1;
        m_old_x    = nx;
        m_old_y    = ny;
    endtask

    always @(negedge clock) begin
        if (resetn === 1'b1 && bus_if.vga_plot === 1'b1) begin
            pix_t e;
            n_plots++;
            check("plot_on_screen", 32'(bus_if.vga_x < 8'd160 && bus_if.vga_y < 7'd120), 32'd1);
            check("plot_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pixel", 32'({bus_if.vga_x, bus_if.vga_y, bus_if.vga_colour}), 32'(e));
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        #1;
        sb.delete();
        m_have_old = 0;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic redraw(input int nx, input int ny, input bit hold, input string tag);
        int exp_done;
        int n;
        int busy_lows;
        bit found;
        @(negedge clock);
        bus_if.x_position = 8'(nx);
        bus_if.y_position = 7'(ny);
        bus_if.enable     = 1'b1;
        push_expected(nx, ny, exp_done);
        n_plots = 0;
        @(posedge clock);
        @(negedge clock);
        // Position changes after the sample must not affect this redraw.
        bus_if.x_position = 8'd3;
        bus_if.y_position = 7'd3;
        if (!hold) bus_if.enable = 1'b0;
        n = 1;
        found = 1'b0;
        busy_lows = 0;
        while (n <= 400) begin
            if (bus_if.busy !== 1'b1) busy_lows++;
            if (bus_if.done === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
            n++;
        end
        check({tag, "_done_seen"}, 32'(found), 32'd1);
        check({tag, "_done_cycle"}, 32'(n), 32'(exp_done));
        check({tag, "_busy_held"}, 32'(busy_lows), 32'd0);
        @(negedge clock);
        #1;
        bus_if.enable = 1'b0;
        check({tag, "_done_pulse"}, 32'(bus_if.done), 32'd0);
        check({tag, "_idle_busy"}, 32'(bus_if.busy), 32'd0);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        check({tag, "_plot_count"}, 32'(n_plots), 32'(exp_plots));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dummy;
        resetn            = 1'b0;
        bus_if.enable     = 1'b0;
        bus_if.x_position = 8'd0;
        bus_if.y_position = 7'd0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_plot",   32'(bus_if.vga_plot),   32'd0);
        check("rst_busy",   32'(bus_if.busy),       32'd0);
        check("rst_done",   32'(bus_if.done),       32'd0);
        check("rst_x",      32'(bus_if.vga_x),      32'd0);
        check("rst_y",      32'(bus_if.vga_y),      32'd0);
        check("rst_colour", 32'(bus_if.vga_colour), 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        redraw(72, 60, 1'b0, "t1_first");
        redraw(73, 60, 1'b0, "t2_move");

        do_reset();
        redraw(156, 116, 1'b0, "t3_clip");

        redraw(30, 20, 1'b1, "t4_hold");
        @(negedge clock);
        #1;
        check("t4_no_retrigger", 32'(bus_if.busy), 32'd0);

        // Reset in the middle of a draw pass.
        do_reset();
        @(negedge clock);
        bus_if.x_position = 8'd20;
        bus_if.y_position = 7'd30;
        bus_if.enable     = 1'b1;
        push_expected(20, 30, dummy);
        @(posedge clock);
        @(negedge clock);
        bus_if.enable = 1'b0;
        repeat (39) @(negedge clock);
        check("t5_plot_before_rst", 32'(bus_if.vga_plot), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("t5_rst_plot", 32'(bus_if.vga_plot), 32'd0);
        check("t5_rst_busy", 32'(bus_if.busy),     32'd0);
        check("t5_rst_done", 32'(bus_if.done),     32'd0);
        sb.delete();
        m_have_old = 0;
        @(negedge clock);
        resetn = 1'b1;
        redraw(10, 10, 1'b0, "t5_after_rst");

        do_reset();
        redraw(40, 40, 1'b0, "t6_full");
`ifdef SPRITE_TRANSPARENCY_EN
        check("t6_plots", 32'(n_plots), 32'd59);
`else
        check("t6_plots", 32'(n_plots), 32'd64);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
